// File: rtl/status_drain_pkg.sv
// status_drain_pkg: exception code constants, drain FSM states and code classification.
package status_drain_pkg;
   localparam logic [31:0] ADD_OVF    = 32'd1;
   localparam logic [31:0] ADDI_OVF   = 32'd2;
   localparam logic [31:0] SUB_OVF    = 32'd3;
   localparam logic [31:0] MUL_EXC    = 32'd4;
   localparam logic [31:0] DIV_EXC    = 32'd5;
   localparam logic [31:0] STATUS_MAX = DIV_EXC;
   localparam int RSTATUS_REG_DEF     = 30;

   typedef enum logic {IDLE, READ} drain_state_t;
   typedef enum logic [1:0] {CODE_ZERO, CODE_OK, CODE_BAD} code_class_t;

   function automatic code_class_t code_class(input logic [31:0] c);
      return (c == '0) ? CODE_ZERO : (c <= STATUS_MAX) ? CODE_OK : CODE_BAD;
   endfunction
endpackage

// File: rtl/status_drain_fifo.sv
// status_fifo: small circular FIFO holding exception codes awaiting a free regfile write slot.
module status_fifo
   import status_drain_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W = 32,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [W-1:0]  i_data,
   output logic [W-1:0]  o_data,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [CW-1:0] r_count;
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr] <= i_data;
   end
   // Depth is a power of two, so pointer overflow is the wrap.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + AW'(1);
         if (i_pop) r_rd <= r_rd + AW'(1);
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end
   assign o_data  = r_mem[r_rd];
   assign o_full  = r_count == CW'(DEPTH);
   assign o_empty = r_count == '0;
   assign o_count = r_count;
endmodule

// File: rtl/status_drain.sv
// status_drain: reads exception codes from the status latch and drains them into $rstatus
// whenever the regfile write port is not taken by normal writeback.
module status_drain
   import status_drain_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int RSTATUS_REG = RSTATUS_REG_DEF
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        status_valid,
   input  logic [31:0] status_bus,
   output logic        status_r_en,
   input  logic        wb_busy,
   output logic        rstatus_we,
   output logic [4:0]  rstatus_addr,
   output logic [31:0] rstatus_data,
   output logic        pending,
   output logic        drop_err,
   output logic        bad_code
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   drain_state_t  r_state;
   logic          r_ren;
   logic          r_drop;
   logic          r_bad;
   logic          w_rd;
   logic          w_ok;
   logic          w_pop;
   logic          w_push;
   logic          w_full;
   logic          w_empty;
   logic [31:0]   w_head;
   logic [CW-1:0] w_count;
   code_class_t   w_class;
   // The bus floats outside READ, so every use of it is qualified by w_rd.
   always_comb begin
      w_rd    = r_state == READ;
      w_class = code_class(status_bus);
      w_ok    = w_rd && w_class == CODE_OK;
      w_pop   = !w_empty && !wb_busy;
      w_push  = w_ok && (!w_full || w_pop);
   end
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= IDLE;
         r_ren   <= 1'b0;
         r_drop  <= 1'b0;
         r_bad   <= 1'b0;
      end else begin
         r_state <= status_valid ? READ : IDLE;
         r_ren   <= status_valid;
         if (w_ok && w_full && !w_pop) r_drop <= 1'b1;
         if (w_rd && w_class == CODE_BAD) r_bad <= 1'b1;
      end
   end
   status_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
      .clk     (clk),
      .clr     (clr),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (status_bus),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );
   assign status_r_en  = r_ren;
   assign rstatus_we   = w_pop;
   assign rstatus_addr = 5'(RSTATUS_REG);
   assign rstatus_data = w_pop ? w_head : '0;
   assign pending      = w_count != '0;
   assign drop_err     = r_drop;
   assign bad_code     = r_bad;
endmodule

// File: tb/tb_status_drain.sv
// tb_status_drain: directed vector table plus a latency sequence for status_drain.
module tb_status_drain;
   logic        clk = 1'b0;
   logic        clr;
   logic        status_valid;
   logic        wb_busy;
   logic [31:0] r_latch;
   logic [31:0] status_bus;
   logic        status_r_en;
   logic        rstatus_we;
   logic [4:0]  rstatus_addr;
   logic [31:0] rstatus_data;
   logic        pending;
   logic        drop_err;
   logic        bad_code;
   int          errors = 0;
   int          checks = 0;

   typedef struct {
      logic        clr, valid, busy;
      logic [31:0] latch;
      logic        ren, we;
      logic [31:0] data;
      logic        pend, drop, bad;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;
   // Garbage stands in for the floating bus so any out-of-READ sample shows up as bad_code.
   assign status_bus = status_r_en ? r_latch : 32'hDEAD_BEEF;

   status_drain #(.FIFO_DEPTH(2), .RSTATUS_REG(30)) dut (
      .clk          (clk),
      .clr          (clr),
      .status_valid (status_valid),
      .status_bus   (status_bus),
      .status_r_en  (status_r_en),
      .wb_busy      (wb_busy),
      .rstatus_we   (rstatus_we),
      .rstatus_addr (rstatus_addr),
      .rstatus_data (rstatus_data),
      .pending      (pending),
      .drop_err     (drop_err),
      .bad_code     (bad_code)
   );

   function automatic vec_t v(logic c, logic vl, logic b, logic [31:0] l,
                              logic re, logic we, logic [31:0] d, logic p, logic dr, logic bd);
      vec_t r;
      r.clr = c; r.valid = vl; r.busy = b; r.latch = l;
      r.ren = re; r.we = we; r.data = d; r.pend = p; r.drop = dr; r.bad = bd;
      return r;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   initial begin
      clr = 1'b1; status_valid = 1'b0; wb_busy = 1'b0; r_latch = '0;
      //             clr vld bsy latch          ren we data pend drop bad
      tbl.push_back(v(1, 0, 0, 32'd0,          0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 0, 32'd3,          0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 32'd3,          1, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 32'd0,          0, 1, 3, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 32'd0,          0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 1, 32'd1,          0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 1, 32'd1,          1, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 32'd4,          1, 0, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 1, 32'd0,          0, 0, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 1, 32'd0,          0, 0, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 32'd0,          0, 1, 1, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 32'd0,          0, 1, 4, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 32'd0,          0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 1, 32'd2,          0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 1, 32'd2,          1, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 1, 32'd5,          1, 0, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 1, 32'd1,          1, 0, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 1, 32'd0,          0, 0, 0, 1, 1, 0));
      tbl.push_back(v(0, 0, 0, 32'd0,          0, 1, 2, 1, 1, 0));
      tbl.push_back(v(0, 0, 0, 32'd0,          0, 1, 5, 1, 1, 0));
      tbl.push_back(v(0, 0, 0, 32'd0,          0, 0, 0, 0, 1, 0));
      tbl.push_back(v(0, 1, 0, 32'd0,          0, 0, 0, 0, 1, 0));
      tbl.push_back(v(0, 0, 0, 32'd0,          1, 0, 0, 0, 1, 0));
      tbl.push_back(v(0, 1, 0, 32'd8,          0, 0, 0, 0, 1, 0));
      tbl.push_back(v(0, 0, 0, 32'd8,          1, 0, 0, 0, 1, 0));
      tbl.push_back(v(0, 1, 0, 32'd6,          0, 0, 0, 0, 1, 1));
      tbl.push_back(v(0, 0, 0, 32'd6,          1, 0, 0, 0, 1, 1));
      tbl.push_back(v(0, 0, 0, 32'd0,          0, 0, 0, 0, 1, 1));
      tbl.push_back(v(1, 0, 0, 32'd0,          0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 1, 32'd1,          0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 1, 32'd1,          1, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 1, 32'd2,          1, 0, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 32'd3,          1, 1, 1, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 32'd0,          0, 1, 2, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 32'd0,          0, 1, 3, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 32'd0,          0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 1, 32'd5,          0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 1, 32'd5,          1, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 0, 1, 32'd4,          0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 32'd0,          0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 32'd0,          0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 0, 32'h8000_0003,  0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 32'h8000_0003,  1, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 32'd0,          0, 0, 0, 0, 0, 1));
      repeat (2) @(posedge clk);
      #1;
      foreach (tbl[i]) begin
         clr = tbl[i].clr; status_valid = tbl[i].valid;
         wb_busy = tbl[i].busy; r_latch = tbl[i].latch;
         #1;
         chk("r_en", i, 32'(status_r_en), 32'(tbl[i].ren));
         chk("we", i, 32'(rstatus_we), 32'(tbl[i].we));
         chk("data", i, rstatus_data, tbl[i].data);
         chk("addr", i, 32'(rstatus_addr), 32'd30);
         chk("pending", i, 32'(pending), 32'(tbl[i].pend));
         chk("drop_err", i, 32'(drop_err), 32'(tbl[i].drop));
         chk("bad_code", i, 32'(bad_code), 32'(tbl[i].bad));
         @(posedge clk);
         #1;
      end
      begin
         int n;
         clr = 1'b0; wb_busy = 1'b0; r_latch = 32'd4; status_valid = 1'b1;
         @(posedge clk);
         #1;
         status_valid = 1'b0;
         n = 1;
         while (!rstatus_we && n < 8) begin
            @(posedge clk);
            #1;
            n++;
         end
         chk("latency", 100, 32'(n), 32'd2);
         chk("lat_data", 100, rstatus_data, 32'd4);
         @(posedge clk);
         #1;
         chk("lat_empty", 101, 32'(pending), 32'd0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/status_drain.md
STATUS_DRAIN -- requirements
Module: status_drain

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, number of buffered exception codes (power of two, >=2).
REQ-002 SHALL have parameter RSTATUS_REG, default 30, register-file index of $rstatus.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port status_valid  input  1  the status latch holds a newly written exception code.
REQ-006 SHALL have port status_bus  input  32  shared tri-state bus, driven by the status latch only while status_r_en=1.
REQ-007 SHALL have port status_r_en  output  1  read enable to the status latch.
REQ-008 SHALL have port wb_busy  input  1  regfile write port used by normal writeback this cycle.
REQ-009 SHALL have port rstatus_we  output  1  regfile write enable for $rstatus.
REQ-010 SHALL have port rstatus_addr  output  5  constant RSTATUS_REG.
REQ-011 SHALL have port rstatus_data  output  32  exception code written to $rstatus.
REQ-012 SHALL have port pending  output  1  FIFO non-empty.
REQ-013 SHALL have port drop_err  output  1  sticky: a valid code was lost to a full FIFO.
REQ-014 SHALL have port bad_code  output  1  sticky: bus value outside 0..5 sampled.

Function
REQ-015 SHALL implement FSM states IDLE and READ; status_r_en=1 only in READ.
REQ-016 IDLE: status_valid=1 at an edge SHALL move to READ; otherwise stay IDLE.
REQ-017 READ: SHALL sample status_bus at the closing edge; status_valid=1 at that edge SHALL remain in READ (back-to-back read), else return to IDLE.
REQ-018 status_bus SHALL never be sampled outside READ (bus is Z then).
REQ-019 Sampled value 0 SHALL be discarded with no flag.
REQ-020 Sampled value 1..5 SHALL be pushed to the FIFO if not full.
REQ-021 Sampled value >5 (any bit [31:3] set, or 6/7) SHALL set bad_code and not be pushed.
REQ-022 Valid code with FIFO full and no pop in the same cycle SHALL set drop_err and be discarded; FIFO contents unchanged.
REQ-023 Pop: when FIFO non-empty and wb_busy=0, rstatus_we=1 and rstatus_data=head combinationally that cycle; head removed at the edge.
REQ-024 rstatus_we=0 and rstatus_data=0 when FIFO empty or wb_busy=1.
REQ-025 Simultaneous push and pop in one cycle SHALL be allowed, including when full; occupancy unchanged.
REQ-026 Latency: status_valid sampled at edge N -> status_r_en high cycle N..N+1 -> code in FIFO after edge N+1 -> earliest rstatus_we in the cycle following edge N+1.
REQ-027 Codes SHALL drain in arrival order; pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-028 drop_err and bad_code SHALL clear only on clr.

Reset
REQ-029 clr SHALL immediately force state IDLE, FIFO empty, status_r_en=0, rstatus_we=0, rstatus_data=0, pending=0, drop_err=0, bad_code=0.
REQ-030 clr mid-READ SHALL abandon the sample; clr with entries pending SHALL discard them (no write).
REQ-031 rstatus_addr SHALL equal RSTATUS_REG in and out of reset.

Structure
REQ-032 Exception code constants (ADD_OVF=1, ADDI_OVF=2, SUB_OVF=3, MUL_EXC=4, DIV_EXC=5), STATUS_MAX=5 and RSTATUS_REG default SHALL live in the shared processor package.
REQ-033 The FIFO SHALL be one sub-module, status_fifo (push, pop, data, full, empty, count).

Verification
REQ-034 Single code: status_valid pulse, bus=3 -> status_r_en one cycle, then rstatus_we=1 one cycle, addr=30, data=3.
REQ-035 Back-to-back: status_valid two cycles, bus=1 then 4, wb_busy=1 for 5 cycles -> pending=1, no write; after release, writes 1 then 4 on consecutive cycles.
REQ-036 Overflow: wb_busy=1, three codes 2,5,1 -> drop_err=1, later writes only 2,5.
REQ-037 Bad/zero: bus=0 -> no write, no flag; bus=32'h8 -> bad_code=1, no write.
REQ-038 Full push+pop: FIFO full, wb_busy=0, new code 3 -> no drop_err, order preserved, 3 written last.
REQ-039 Reset: clr asserted mid-READ with 1 entry pending -> all outputs 0 immediately, no later write of that entry.
